// File: rtl/seq_det_pkg.sv
// Shared constants, select encoding and pattern table for the serial sequence detector.
package seq_det_pkg;

    localparam int SEQ_LEN_DEF = 5;
    localparam int CNT_W_DEF   = 16;

    typedef enum logic [1:0] {
        SEL_A = 2'b00,
        SEL_B = 2'b01,
        SEL_C = 2'b10,
        SEL_D = 2'b11
    } sel_t;

    // First-received bit is the MSB of each word.
    localparam logic [SEQ_LEN_DEF-1:0] PATTERN [4] = '{
        5'b10111,
        5'b11010,
        5'b01101,
        5'b10010
    };

endpackage

// File: rtl/sequence_detector_if.sv
// Serial data in, pattern select in, detection pulse and count out.
interface sequence_detector_if
    import seq_det_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);

    logic             input_seq;
    logic [1:0]       lookfor_seq;
    logic             seq_detected;
    logic [CNT_W-1:0] dseq_count;

    modport master (
        output input_seq,
        output lookfor_seq,
        input  seq_detected,
        input  dseq_count
    );

    modport slave (
        input  input_seq,
        input  lookfor_seq,
        output seq_detected,
        output dseq_count
    );

endinterface

// File: rtl/seq_det_counter.sv
// Saturating up-counter: increments on inc and sticks at all-ones.
module seq_det_counter
    import seq_det_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (inc && (count_reg != {CNT_W{1'b1}})) begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/sequence_detector.sv
// Overlapping serial pattern detector with selectable 5-bit pattern and saturating hit count.
module sequence_detector
    import seq_det_pkg::*;
#(
    parameter int SEQ_LEN = SEQ_LEN_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    sequence_detector_if.slave  bus
);

    localparam int FILL_W = $clog2(SEQ_LEN + 1);

    // Only the previous SEQ_LEN-1 bits are kept; the oldest would shift out before any compare.
    logic [SEQ_LEN-2:0] hist_reg;
    logic [FILL_W-1:0]  fill_reg;
    sel_t               sel_reg;
    logic               det_reg;

    logic [SEQ_LEN-1:0] hist_next;
    logic [FILL_W-1:0]  fill_next;
    logic               sel_changed;
    logic               sel_hit;
    logic               match;
    logic [3:0]         pat_hit;

    always_comb begin
        hist_next   = {hist_reg, bus.input_seq};
        fill_next   = (fill_reg == FILL_W'(SEQ_LEN)) ? fill_reg : fill_reg + 1'b1;
        sel_changed = (bus.lookfor_seq != sel_reg);
        // A new selection restarts the history so stale bits never meet the new pattern.
        if (sel_changed) begin
            hist_next = {{(SEQ_LEN-1){1'b0}}, bus.input_seq};
            fill_next = FILL_W'(1);
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_pat
            assign pat_hit[gi] = (hist_next == PATTERN[gi]);
        end
    endgenerate

    // Unknown select values fall to the default arm and never match.
    always_comb begin
        sel_hit = 1'b0;
        case (bus.lookfor_seq)
            SEL_A:   sel_hit = pat_hit[0];
            SEL_B:   sel_hit = pat_hit[1];
            SEL_C:   sel_hit = pat_hit[2];
            SEL_D:   sel_hit = pat_hit[3];
            default: sel_hit = 1'b0;
        endcase
    end

    assign match = !sel_changed && (fill_next == FILL_W'(SEQ_LEN)) && sel_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_reg <= '0;
            fill_reg <= '0;
            sel_reg  <= SEL_A;
            det_reg  <= 1'b0;
        end else begin
            hist_reg <= hist_next[SEQ_LEN-2:0];
            fill_reg <= fill_next;
            sel_reg  <= sel_t'(bus.lookfor_seq);
            det_reg  <= match;
        end
    end

    seq_det_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk   (clk),
        .rst_n (reset),
        .inc   (match),
        .count (bus.dseq_count)
    );

    assign bus.seq_detected = det_reg;

endmodule

// File: tb/tb_sequence_detector.sv
// Drives a 16-bit-count detector and a 2-bit-count twin from one stream and scores both.
module tb_sequence_detector;

    logic clk;
    logic reset;

    sequence_detector_if #(.CNT_W(16)) bus ();
    sequence_detector_if #(.CNT_W(2))  sat_bus ();

    assign sat_bus.input_seq   = bus.input_seq;
    assign sat_bus.lookfor_seq = bus.lookfor_seq;

    sequence_detector #(.SEQ_LEN(5), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    sequence_detector #(.SEQ_LEN(5), .CNT_W(2)) dut_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (sat_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit det;
        int cnt;
    } exp_t;

    typedef struct {
        bit         b;
        logic [1:0] sel;
        bit         det;
        int         cnt;
    } vec_t;

    exp_t sb[$];
    vec_t tab[$];

    // Reference model: a run length since the last restart and a 5-bit window.
    int         m_run;
    logic [4:0] m_win;
    logic [1:0] m_sel;
    int         m_cnt;

    function automatic logic [4:0] ref_pat(input logic [1:0] s);
        logic [4:0] p;
        case (s)
            2'd0:    p = 5'b10111;
            2'd1:    p = 5'b11010;
            2'd2:    p = 5'b01101;
            default: p = 5'b10010;
        endcase
        return p;
    endfunction

    task automatic model_reset();
        m_run = 0;
        m_win = '0;
        m_sel = 2'd0;
        m_cnt = 0;
    endtask

    task automatic model_edge(input bit b, input logic [1:0] s, output bit det);
        if (s != m_sel) m_run = 0;
        m_sel = s;
        m_win = {m_win[3:0], b};
        if (m_run < 5) m_run++;
        det = (m_run == 5) && (m_win == ref_pat(s));
        if (det && m_cnt < 65535) m_cnt++;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input bit b, input logic [1:0] s, input bit det, input int cnt);
        vec_t v;
        v.b = b; v.sel = s; v.det = det; v.cnt = cnt;
        tab.push_back(v);
    endtask

    task automatic step(input bit b, input logic [1:0] s, input bit use_tab,
                        input bit tdet, input int tcnt, input string tag);
        exp_t e;
        bit   mdet;
        int   sat_cnt;
        bus.input_seq   = b;
        bus.lookfor_seq = s;
        model_edge(b, s, mdet);
        e.det = use_tab ? tdet : mdet;
        e.cnt = use_tab ? tcnt : m_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        sat_cnt = (e.cnt > 3) ? 3 : e.cnt;
        check({tag, " det"},     64'(bus.seq_detected),     64'(e.det));
        check({tag, " cnt"},     64'(bus.dseq_count),       64'(e.cnt));
        check({tag, " sat_det"}, 64'(sat_bus.seq_detected), 64'(e.det));
        check({tag, " sat_cnt"}, 64'(sat_bus.dseq_count),   64'(sat_cnt));
        $display("%s bit=%0b sel=%0d det=%0b cnt=%0d sat_cnt=%0d", tag, b, s,
                 bus.seq_detected, bus.dseq_count, sat_bus.dseq_count);
    endtask

    task automatic check_zero(input string tag);
        check({tag, " det"},     64'(bus.seq_detected),     64'd0);
        check({tag, " cnt"},     64'(bus.dseq_count),       64'd0);
        check({tag, " sat_cnt"}, 64'(sat_bus.dseq_count),   64'd0);
        $display("%s det=%0b cnt=%0d", tag, bus.seq_detected, bus.dseq_count);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Basic match, then overlap including a near-miss stream.
        add(1,0,0,0); add(0,0,0,0); add(1,0,0,0); add(1,0,0,0); add(1,0,1,1);
        add(0,0,0,1); add(1,0,0,1); add(1,0,0,1); add(1,0,1,2);
        add(1,0,0,2); add(0,0,0,2); add(1,0,0,2); add(1,0,0,2);
        add(0,0,0,2); add(1,0,0,2); add(1,0,0,2); add(1,0,1,3);
        // Each remaining pattern, then a non-matching stream.
        add(1,1,0,3); add(1,1,0,3); add(0,1,0,3); add(1,1,0,3); add(0,1,1,4);
        for (int i = 0; i < 5; i++) add(1,1,0,4);
        add(0,2,0,4); add(1,2,0,4); add(1,2,0,4); add(0,2,0,4); add(1,2,1,5);
        for (int i = 0; i < 5; i++) add(1,2,0,5);
        add(1,3,0,5); add(0,3,0,5); add(0,3,0,5); add(1,3,0,5); add(0,3,1,6);
        for (int i = 0; i < 5; i++) add(1,3,0,6);
        for (int i = 0; i < 5; i++) add(1,0,0,6);
        // Selection change restarts detection.
        add(1,0,0,6); add(0,0,0,6); add(1,0,0,6); add(1,0,0,6);
        add(1,1,0,6); add(1,1,0,6); add(0,1,0,6); add(1,1,0,6); add(0,1,1,7);
        // Stale window 11010 must not match right after switching to 01.
        add(1,0,0,7); add(1,0,0,7); add(0,0,0,7); add(1,0,0,7);
        add(0,1,0,7); add(1,1,0,7); add(1,1,0,7); add(0,1,0,7); add(1,1,0,7); add(0,1,1,8);

        model_reset();
        bus.input_seq   = 1'b0;
        bus.lookfor_seq = 2'd0;
        reset = 1'b0;
        #3;
        check_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset_hold");
        reset = 1'b1;

        for (int i = 0; i < tab.size(); i++) begin
            step(tab[i].b, tab[i].sel, 1'b1, tab[i].det, tab[i].cnt, $sformatf("vec%0d", i));
        end

        // Asynchronous reset between edges discards the partial match.
        step(1, 0, 1'b0, 0, 0, "pre_rst");
        step(0, 0, 1'b0, 0, 0, "pre_rst");
        step(1, 0, 1'b0, 0, 0, "pre_rst");
        step(1, 0, 1'b0, 0, 0, "pre_rst");
        #2;
        reset = 1'b0;
        #1;
        check_zero("async_rst");
        bus.input_seq = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_zero("async_rst_hold");
        reset = 1'b1;
        model_reset();
        step(1, 0, 1'b1, 0, 0, "post_rst");
        step(1, 0, 1'b1, 0, 0, "post_rst");
        step(0, 0, 1'b1, 0, 0, "post_rst");
        step(1, 0, 1'b1, 0, 0, "post_rst");
        step(1, 0, 1'b1, 0, 0, "post_rst");
        step(1, 0, 1'b1, 1, 1, "post_rst");

        // Drive the 2-bit twin well past saturation.
        for (int k = 0; k < 4; k++) begin
            step(1, 0, 1'b0, 0, 0, "sat");
            step(0, 0, 1'b0, 0, 0, "sat");
            step(1, 0, 1'b0, 0, 0, "sat");
            step(1, 0, 1'b0, 0, 0, "sat");
            step(1, 0, 1'b0, 0, 0, "sat");
        end
        check("sat_final", 64'(sat_bus.dseq_count), 64'd3);

        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < 100; i++) begin
                step(1'($urandom_range(0, 1)), 2'(s), 1'b0, 0, 0, $sformatf("soak_sel%0d", s));
            end
        end
        for (int i = 0; i < 100; i++) begin
            logic [1:0] rs;
            rs = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : m_sel;
            step(1'($urandom_range(0, 1)), rs, 1'b0, 0, 0, "soak_mix");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
